// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: h/v counters with registered sync, blank,
// data-enable, coordinate and frame-count outputs, plus a run/drain/idle controller.
module video_timing_gen #(
    parameter int CW       = 12,
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int PF_LINES = 2
) (
    input  logic          video_clk,
    input  logic          reset,
    input  logic          run,
    output logic          busy,
    output logic          framestart,
    output logic          linestart,
    output logic          prefetch_line,
    output logic          pixelena,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic [15:0]   frame_cnt
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CW:0] H_LAST     = (CW+1)'(H_TOTAL - 1);
    localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_SYNC);
    localparam logic [CW:0] H_ACT_BEG  = (CW+1)'(H_SYNC + H_BP);
    localparam logic [CW:0] H_ACT_END  = (CW+1)'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW:0] V_LAST     = (CW+1)'(V_TOTAL - 1);
    localparam logic [CW:0] V_TOT      = (CW+1)'(V_TOTAL);
    localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_SYNC);
    localparam logic [CW:0] V_ACT_BEG  = (CW+1)'(V_SYNC + V_BP);
    localparam logic [CW:0] V_ACT_END  = (CW+1)'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [CW:0] PF_LEAD    = (CW+1)'(PF_LINES);
    localparam logic        HS_ON      = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic        VS_ON      = (VS_POL != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_run;
    logic [CW-1:0] r_h, r_v;
    logic [CW:0]   w_h, w_v, w_v_pf_raw, w_v_pf;
    logic [CW-1:0] w_px, w_py;
    logic          w_advance, w_h_last, w_frame_end, w_frame_start;
    logic          w_h_act, w_v_act, w_pf_act;

    logic          r_busy, r_framestart, r_linestart, r_prefetch, r_pixelena;
    logic          r_hsync, r_vsync, r_hblank, r_vblank;
    logic [CW-1:0] r_pix_x, r_pix_y;
    logic [15:0]   r_frame_cnt;

    assign w_h           = {1'b0, r_h};
    assign w_v           = {1'b0, r_v};
    assign w_advance     = (r_state != S_IDLE);
    assign w_h_last      = (w_h == H_LAST);
    assign w_frame_end   = w_h_last && (w_v == V_LAST);
    assign w_frame_start = (r_h == '0) && (r_v == '0);
    assign w_h_act       = (w_h >= H_ACT_BEG) && (w_h < H_ACT_END);
    assign w_v_act       = (w_v >= V_ACT_BEG) && (w_v < V_ACT_END);
    // The prefetch target line wraps into the next frame near the bottom.
    assign w_v_pf_raw    = w_v + PF_LEAD;
    assign w_v_pf        = (w_v_pf_raw >= V_TOT) ? (w_v_pf_raw - V_TOT) : w_v_pf_raw;
    assign w_pf_act      = (w_v_pf >= V_ACT_BEG) && (w_v_pf < V_ACT_END);
    assign w_px          = r_h - H_ACT_BEG[CW-1:0];
    assign w_py          = r_v - V_ACT_BEG[CW-1:0];

    always_ff @(posedge video_clk) begin
        if (reset) begin
            r_run   <= 1'b0;
            r_state <= S_IDLE;
        end else begin
            r_run   <= run;
            r_state <= w_state_nxt;
        end
    end

    // A frame boundary decides whether another frame follows, so stopping never truncates.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_run) w_state_nxt = S_RUN;
                else       w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (r_run)            w_state_nxt = S_RUN;
                else if (w_frame_end) w_state_nxt = S_IDLE;
                else                  w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_run)            w_state_nxt = S_RUN;
                else if (w_frame_end) w_state_nxt = S_IDLE;
                else                  w_state_nxt = S_DRAIN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge video_clk) begin
        if (reset || !w_advance) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            if (w_v == V_LAST) r_v <= '0;
            else               r_v <= r_v + CW'(1);
        end else begin
            r_h <= r_h + CW'(1);
        end
    end

    always_ff @(posedge video_clk) begin
        if (reset || !w_advance) begin
            r_busy       <= 1'b0;
            r_framestart <= 1'b0;
            r_linestart  <= 1'b0;
            r_prefetch   <= 1'b0;
            r_pixelena   <= 1'b0;
            r_hsync      <= ~HS_ON;
            r_vsync      <= ~VS_ON;
            r_hblank     <= 1'b1;
            r_vblank     <= 1'b1;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
        end else begin
            r_busy       <= 1'b1;
            r_framestart <= w_frame_start;
            r_linestart  <= (r_h == '0) && w_v_act;
            r_prefetch   <= (r_h == '0) && w_pf_act;
            r_pixelena   <= w_h_act && w_v_act;
            r_hsync      <= (w_h < H_SYNC_END) ? HS_ON : ~HS_ON;
            r_vsync      <= (w_v < V_SYNC_END) ? VS_ON : ~VS_ON;
            r_hblank     <= ~w_h_act;
            r_vblank     <= ~w_v_act;
            r_pix_x      <= (w_h_act && w_v_act) ? w_px : '0;
            r_pix_y      <= (w_h_act && w_v_act) ? w_py : '0;
        end
    end

    always_ff @(posedge video_clk) begin
        if (reset)                           r_frame_cnt <= 16'd0;
        else if (w_advance && w_frame_start) r_frame_cnt <= r_frame_cnt + 16'd1;
        else                                 r_frame_cnt <= r_frame_cnt;
    end

    assign busy          = r_busy;
    assign framestart    = r_framestart;
    assign linestart     = r_linestart;
    assign prefetch_line = r_prefetch;
    assign pixelena      = r_pixelena;
    assign hsync         = r_hsync;
    assign vsync         = r_vsync;
    assign hblank        = r_hblank;
    assign vblank        = r_vblank;
    assign pix_x         = r_pix_x;
    assign pix_y         = r_pix_y;
    assign frame_cnt     = r_frame_cnt;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small raster, with active-high and active-low sync
// instances checked every cycle against a frame-position reference model.
module tb_video_timing_gen;
    localparam int CW  = 6;
    localparam int HA  = 8, HFP = 1, HS = 2, HBP = 1;
    localparam int VA  = 4, VFP = 1, VS = 1, VBP = 2;
    localparam int PF  = 2;
    localparam int HT  = HS + HBP + HA + HFP;
    localparam int VT  = VS + VBP + VA + VFP;
    localparam int FT  = HT * VT;

    typedef struct packed {
        logic busy, fs, ls, pf, de, hs, vs, hb, vb;
        logic [CW-1:0] px, py;
    } exp_t;

    logic clk = 1'b0;
    logic reset, run;
    logic busy, framestart, linestart, prefetch_line, pixelena, hsync, vsync, hblank, vblank;
    logic [CW-1:0] pix_x, pix_y;
    logic [15:0] frame_cnt;
    logic busy_n, framestart_n, linestart_n, prefetch_n, pixelena_n, hsync_n, vsync_n, hblank_n, vblank_n;
    logic [CW-1:0] pix_x_n, pix_y_n;
    logic [15:0] frame_cnt_n;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    video_timing_gen #(.CW(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                       .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                       .HS_POL(1), .VS_POL(1), .PF_LINES(PF)) dut (
        .video_clk(clk), .reset(reset), .run(run), .busy(busy), .framestart(framestart),
        .linestart(linestart), .prefetch_line(prefetch_line), .pixelena(pixelena),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .pix_x(pix_x), .pix_y(pix_y), .frame_cnt(frame_cnt));

    video_timing_gen #(.CW(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                       .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                       .HS_POL(0), .VS_POL(0), .PF_LINES(PF)) dut_n (
        .video_clk(clk), .reset(reset), .run(run), .busy(busy_n), .framestart(framestart_n),
        .linestart(linestart_n), .prefetch_line(prefetch_n), .pixelena(pixelena_n),
        .hsync(hsync_n), .vsync(vsync_n), .hblank(hblank_n), .vblank(vblank_n),
        .pix_x(pix_x_n), .pix_y(pix_y_n), .frame_cnt(frame_cnt_n));

    function automatic logic act_line(int y);
        return (y >= VS + VBP) && (y < VS + VBP + VA);
    endfunction

    // Expected outputs for frame position p (raster order), or idle when p < 0.
    function automatic exp_t decode(int p);
        exp_t e;
        int   x, y;
        logic ha, va;
        e    = '0;
        e.hb = 1'b1;
        e.vb = 1'b1;
        if (p >= 0) begin
            x    = p % HT;
            y    = p / HT;
            ha   = (x >= HS + HBP) && (x < HS + HBP + HA);
            va   = act_line(y);
            e.busy = 1'b1;
            e.fs = (p == 0);
            e.ls = (x == 0) && va;
            e.pf = (x == 0) && act_line((y + PF) % VT);
            e.de = ha && va;
            e.hs = (x < HS);
            e.vs = (y < VS);
            e.hb = !ha;
            e.vb = !va;
            if (ha && va) begin
                e.px = CW'(x - (HS + HBP));
                e.py = CW'(y - (VS + VBP));
            end
        end
        return e;
    endfunction

    // Model: run seen one edge late; another frame starts only if run is seen at its boundary.
    int          m_pos = -1;
    logic        m_run_d = 1'b0;
    exp_t        m_exp;
    logic [15:0] m_fc = 16'd0;

    always @(posedge clk) begin
        if (reset) begin
            m_pos   <= -1;
            m_run_d <= 1'b0;
            m_exp   <= decode(-1);
            m_fc    <= 16'd0;
        end else begin
            m_exp   <= decode(m_pos);
            if (m_pos == 0) m_fc <= m_fc + 16'd1;
            m_run_d <= run;
            if (m_pos < 0 || m_pos == FT - 1) m_pos <= m_run_d ? 0 : -1;
            else                              m_pos <= m_pos + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_inst(input string n, input logic pol, input logic b, input logic fs,
                              input logic ls, input logic pf, input logic de, input logic hs,
                              input logic vs, input logic hb, input logic vb,
                              input logic [CW-1:0] px, input logic [CW-1:0] py,
                              input logic [15:0] fc);
        logic ehs, evs;
        ehs = pol ? m_exp.hs : !m_exp.hs;
        evs = pol ? m_exp.vs : !m_exp.vs;
        chk({n, ".busy"},      32'(b),  32'(m_exp.busy));
        chk({n, ".framestart"},32'(fs), 32'(m_exp.fs));
        chk({n, ".linestart"}, 32'(ls), 32'(m_exp.ls));
        chk({n, ".prefetch"},  32'(pf), 32'(m_exp.pf));
        chk({n, ".pixelena"},  32'(de), 32'(m_exp.de));
        chk({n, ".hsync"},     32'(hs), 32'(ehs));
        chk({n, ".vsync"},     32'(vs), 32'(evs));
        chk({n, ".hblank"},    32'(hb), 32'(m_exp.hb));
        chk({n, ".vblank"},    32'(vb), 32'(m_exp.vb));
        chk({n, ".pix_x"},     32'(px), 32'(m_exp.px));
        chk({n, ".pix_y"},     32'(py), 32'(m_exp.py));
        chk({n, ".frame_cnt"}, 32'(fc), 32'(m_fc));
    endtask

    task automatic tick();
        @(negedge clk);
        check_inst("pos", 1'b1, busy, framestart, linestart, prefetch_line, pixelena, hsync, vsync,
                   hblank, vblank, pix_x, pix_y, frame_cnt);
        check_inst("neg", 1'b0, busy_n, framestart_n, linestart_n, prefetch_n, pixelena_n, hsync_n,
                   vsync_n, hblank_n, vblank_n, pix_x_n, pix_y_n, frame_cnt_n);
    endtask

    initial begin
        int n_ls, n_de, n_pf, n_hs, n_vs, cnt;
        logic done, seen_first;
        logic [CW-1:0] fx, fy, lx, ly;
        logic [15:0] fc_snap;

        reset = 1'b1;
        run   = 1'b0;
        repeat (3) tick();
        chk("rst_busy",    32'(busy),      32'd0);
        chk("rst_hsync",   32'(hsync),     32'd0);
        chk("rst_hsync_n", 32'(hsync_n),   32'd1);
        chk("rst_vsync_n", 32'(vsync_n),   32'd1);
        chk("rst_blank",   32'({hblank, vblank}), 32'd3);
        chk("rst_fc",      32'(frame_cnt), 32'd0);

        // Release with run high: framestart appears on the third cycle.
        reset = 1'b0;
        run   = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("start_latency", 32'(framestart), 32'(i == 3));
        end

        // One full frame: event counts, first/last pixel coordinates, frame period.
        n_ls = 0; n_de = 0; n_pf = 0; n_hs = 0; n_vs = 0;
        seen_first = 1'b0; fx = '0; fy = '0; lx = '0; ly = '0;
        for (int i = 0; i < FT; i++) begin
            if (i > 0) tick();
            n_ls += int'(linestart);
            n_pf += int'(prefetch_line);
            n_hs += int'(hsync);
            n_vs += int'(vsync);
            if (pixelena) begin
                n_de++;
                if (!seen_first) begin fx = pix_x; fy = pix_y; seen_first = 1'b1; end
                lx = pix_x;
                ly = pix_y;
            end
        end
        tick();
        chk("frame_period", 32'(framestart), 32'd1);
        chk("n_linestart",  32'(n_ls), 32'(VA));
        chk("n_pixelena",   32'(n_de), 32'(HA * VA));
        chk("n_prefetch",   32'(n_pf), 32'(VA));
        chk("n_hsync",      32'(n_hs), 32'(HS * VT));
        chk("n_vsync",      32'(n_vs), 32'(VS * HT));
        chk("first_pix",    32'({fx, fy}), 32'd0);
        chk("last_pix",     32'({lx, ly}), 32'({CW'(HA - 1), CW'(VA - 1)}));

        // Drop run mid-frame: frame completes, then idle with frame_cnt frozen.
        repeat (30) tick();
        run  = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 2 * FT && !done; i++) begin
            tick();
            if (!busy) done = 1'b1;
        end
        chk("drain_done", 32'(done), 32'd1);
        fc_snap = frame_cnt;
        repeat (20) tick();
        chk("idle_fc_frozen", 32'(frame_cnt), 32'(fc_snap));
        chk("idle_sync_n",    32'({hsync_n, vsync_n}), 32'd3);

        // Re-raise run while draining: the next framestart is exactly one period later.
        run  = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            if (framestart) done = 1'b1;
        end
        chk("restart_fs", 32'(done), 32'd1);
        cnt  = 0;
        done = 1'b0;
        while (cnt < 3 * FT && !done) begin
            tick();
            cnt++;
            if (cnt == 40) run = 1'b0;
            if (cnt == 55) run = 1'b1;
            if (framestart) done = 1'b1;
        end
        chk("no_gap_period", 32'(cnt), 32'(FT));

        // Random run toggling; the model checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) run = !run;
            tick();
        end

        // Reset in the middle of an active line.
        run  = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 3 * FT && !done; i++) begin
            tick();
            if (pixelena) done = 1'b1;
        end
        chk("midline_found", 32'(done), 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_busy", 32'(busy),      32'd0);
        chk("midrst_de",   32'(pixelena),  32'd0);
        chk("midrst_fc",   32'(frame_cnt), 32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("rst_release_latency", 32'(framestart), 32'(i == 3));
        end
        repeat (FT + 5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
